// File: rtl/fir_ctrl_param.sv
// fir_ctrl_param: FIR tap sequencer with ping-pong coefficient banks.
// Ports: iClk_12M/iRst clock and sync reset; host coefficient port
//   (iCoeffiUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWrDtRam);
//   sample handshake iInValid/oInReady; SpSram port (oCsnRam, oWrnRam,
//   oAddrRam, oBankRam, oWrDtRam); datapath strobes oEnDelay, oClrAcc,
//   oEnAcc, oOutValid; sticky oErrAddr for out-of-range writes.
module fir_ctrl_param #(
   parameter int NUM_TAP = 10,
   parameter int ADDR_W  = 6,
   parameter int COEF_W  = 16
) (
   input  logic              iClk_12M,
   input  logic              iRst,
   input  logic              iCoeffiUpdateFlag,
   input  logic              iCsnRam,
   input  logic              iWrnRam,
   input  logic [ADDR_W-1:0] iAddrRam,
   input  logic [COEF_W-1:0] iWrDtRam,
   input  logic              iInValid,
   output logic              oInReady,
   output logic              oCsnRam,
   output logic              oWrnRam,
   output logic [ADDR_W-1:0] oAddrRam,
   output logic              oBankRam,
   output logic [COEF_W-1:0] oWrDtRam,
   output logic              oEnDelay,
   output logic              oClrAcc,
   output logic              oEnAcc,
   output logic              oOutValid,
   output logic              oErrAddr
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WRITE = 3'd1;
   localparam logic [2:0] SWAP  = 3'd2;
   localparam logic [2:0] MAC   = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;

   localparam logic [ADDR_W-1:0] LastTap = ADDR_W'(NUM_TAP - 1);
   localparam logic [ADDR_W:0]   TapCnt  = (ADDR_W + 1)'(NUM_TAP);

   logic [2:0]        rState;
   logic [2:0]        nState;
   logic              rActBank;
   logic              rPend;
   logic [ADDR_W-1:0] rTap;
   logic              rEnAcc;
   logic              rClrAcc;
   logic              rLastAcc;
   logic              rOutValid;
   logic              rErrAddr;

   logic hs;
   logic hostWr;
   logic addrOk;
   logic lastTap;

   assign hs      = (rState == IDLE) && iInValid;
   assign hostWr  = (rState == WRITE) && !iCsnRam && !iWrnRam;
   assign addrOk  = {1'b0, iAddrRam} < TapCnt;
   assign lastTap = (rTap == LastTap);

   // A sample wins over an update request in IDLE; a request seen
   // while a sample is in flight is held in rPend and taken at DRAIN.
   always_comb begin
      nState = rState;
      case (rState)
         IDLE: begin
            if (iInValid)               nState = MAC;
            else if (iCoeffiUpdateFlag) nState = WRITE;
         end
         WRITE: begin
            if (!iCoeffiUpdateFlag) nState = SWAP;
         end
         SWAP:  nState = IDLE;
         MAC: begin
            if (lastTap) nState = DRAIN;
         end
         DRAIN: begin
            if (rPend || iCoeffiUpdateFlag) nState = WRITE;
            else                            nState = IDLE;
         end
         default: nState = IDLE;
      endcase
   end

   // Host writes land in the shadow bank; MAC reads the active bank.
   always_comb begin
      oInReady = (rState == IDLE);
      oEnDelay = hs;
      oCsnRam  = 1'b1;
      oWrnRam  = 1'b1;
      oAddrRam = '0;
      oWrDtRam = '0;
      oBankRam = rActBank;
      if (hostWr && addrOk) begin
         oCsnRam  = 1'b0;
         oWrnRam  = 1'b0;
         oAddrRam = iAddrRam;
         oWrDtRam = iWrDtRam;
         oBankRam = ~rActBank;
      end else if (rState == MAC) begin
         oCsnRam  = 1'b0;
         oAddrRam = rTap;
      end
   end

   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         rState    <= IDLE;
         rActBank  <= 1'b0;
         rPend     <= 1'b0;
         rTap      <= '0;
         rEnAcc    <= 1'b0;
         rClrAcc   <= 1'b0;
         rLastAcc  <= 1'b0;
         rOutValid <= 1'b0;
         rErrAddr  <= 1'b0;
      end else begin
         rState <= nState;
         if (rState == SWAP) rActBank <= ~rActBank;
         if (rState == DRAIN) rPend <= 1'b0;
         else if (hs || rState == MAC)
            rPend <= rPend | iCoeffiUpdateFlag;
         if (hs) rTap <= '0;
         else if (rState == MAC) rTap <= rTap + 1'b1;
         // SpSram data arrives one cycle after each MAC read.
         rEnAcc    <= (rState == MAC);
         rClrAcc   <= (rState == MAC) && (rTap == '0);
         rLastAcc  <= (rState == MAC) && lastTap;
         rOutValid <= rLastAcc;
         if (hostWr && !addrOk) rErrAddr <= 1'b1;
      end
   end

   assign oEnAcc    = rEnAcc;
   assign oClrAcc   = rClrAcc;
   assign oOutValid = rOutValid;
   assign oErrAddr  = rErrAddr;

endmodule

// File: tb/tb_fir_ctrl_param.sv
// tb_fir_ctrl_param: randomized bench for fir_ctrl_param with an SpSram,
// delay line and accumulator around the DUT and a dot-product model.
module tb_fir_ctrl_param;

   localparam int N  = 10;
   localparam int AW = 6;
   localparam int CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          iRst;
   logic          flag;
   logic          csn;
   logic          wrn;
   logic [AW-1:0] addr;
   logic [CW-1:0] wdt;
   logic          inValid;
   logic signed [CW-1:0] sample;

   logic          inReady, csnR, wrnR, bankR;
   logic          enDelay, clrAcc, enAcc, outValid, errAddr;
   logic [AW-1:0] addrR;
   logic [CW-1:0] wdtR;

   logic          inReady2, csn2, wrn2, bank2;
   logic          enDelay2, clrAcc2, enAcc2, outValid2, errAddr2;
   logic [AW-1:0] addr2;
   logic [CW-1:0] wdt2;

   logic          inReady64, csn64, wrn64, bank64;
   logic          enDelay64, clrAcc64, enAcc64, outValid64, errAddr64;
   logic [AW-1:0] addr64;
   logic [CW-1:0] wdt64;

   fir_ctrl_param #(.NUM_TAP(N), .ADDR_W(AW), .COEF_W(CW)) dut (
      .iClk_12M(clk), .iRst(iRst), .iCoeffiUpdateFlag(flag),
      .iCsnRam(csn), .iWrnRam(wrn), .iAddrRam(addr), .iWrDtRam(wdt),
      .iInValid(inValid), .oInReady(inReady), .oCsnRam(csnR),
      .oWrnRam(wrnR), .oAddrRam(addrR), .oBankRam(bankR),
      .oWrDtRam(wdtR), .oEnDelay(enDelay), .oClrAcc(clrAcc),
      .oEnAcc(enAcc), .oOutValid(outValid), .oErrAddr(errAddr)
   );

   fir_ctrl_param #(.NUM_TAP(2), .ADDR_W(AW), .COEF_W(CW)) dut2 (
      .iClk_12M(clk), .iRst(iRst), .iCoeffiUpdateFlag(flag),
      .iCsnRam(csn), .iWrnRam(wrn), .iAddrRam(addr), .iWrDtRam(wdt),
      .iInValid(inValid), .oInReady(inReady2), .oCsnRam(csn2),
      .oWrnRam(wrn2), .oAddrRam(addr2), .oBankRam(bank2),
      .oWrDtRam(wdt2), .oEnDelay(enDelay2), .oClrAcc(clrAcc2),
      .oEnAcc(enAcc2), .oOutValid(outValid2), .oErrAddr(errAddr2)
   );

   fir_ctrl_param #(.NUM_TAP(64), .ADDR_W(AW), .COEF_W(CW)) dut64 (
      .iClk_12M(clk), .iRst(iRst), .iCoeffiUpdateFlag(flag),
      .iCsnRam(csn), .iWrnRam(wrn), .iAddrRam(addr), .iWrDtRam(wdt),
      .iInValid(inValid), .oInReady(inReady64), .oCsnRam(csn64),
      .oWrnRam(wrn64), .oAddrRam(addr64), .oBankRam(bank64),
      .oWrDtRam(wdt64), .oEnDelay(enDelay64), .oClrAcc(clrAcc64),
      .oEnAcc(enAcc64), .oOutValid(outValid64), .oErrAddr(errAddr64)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: coefficient banks as the host sees them, active bank,
   // and the FIR sample history (index 0 newest).
   logic signed [CW-1:0] coefM [2][N];
   bit                   mAct;
   logic signed [CW-1:0] xM [N];

   // Environment hardware: SpSram, delay line, accumulator.
   logic signed [CW-1:0] mem [2][64];
   logic signed [CW-1:0] xLine [64];
   logic signed [CW-1:0] rdQ;
   int                   rdTapQ;
   longint               acc;
   bit                   memInit = 1'b0;
   longint               gotQ [$];
   longint               expQ [$];

   always @(negedge clk) begin : emu
      longint s;
      if (iRst) begin
         if (!memInit) begin
            foreach (mem[b, k]) mem[b][k] = '0;
            memInit = 1'b1;
         end
         foreach (xLine[k]) xLine[k] = '0;
         foreach (xM[k]) xM[k] = '0;
         acc = 0;
         rdQ = '0;
         rdTapQ = 0;
      end else begin
         if (outValid) gotQ.push_back(acc);
         if (enAcc)
            acc = (clrAcc ? 64'sd0 : acc) +
                  longint'(rdQ) * longint'(xLine[rdTapQ]);
         if (!csnR && !wrnR) mem[bankR][addrR] = wdtR;
         rdQ = mem[bankR][addrR];
         rdTapQ = int'(addrR);
         if (enDelay) begin
            for (int k = 63; k > 0; k--) xLine[k] = xLine[k-1];
            xLine[0] = sample;
         end
         if (inValid && inReady) begin
            for (int k = N - 1; k > 0; k--) xM[k] = xM[k-1];
            xM[0] = sample;
            s = 0;
            for (int k = 0; k < N; k++)
               s += longint'(coefM[mAct][k]) * longint'(xM[k]);
            expQ.push_back(s);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleIn();
      flag = 1'b0;
      csn = 1'b1;
      wrn = 1'b1;
      addr = '0;
      wdt = '0;
      inValid = 1'b0;
   endtask

   task automatic doReset();
      step();
      iRst = 1'b1;
      idleIn();
      step();
      step();
      iRst = 1'b0;
      mAct = 1'b0;
   endtask

   task automatic closeWindow();
      step();
      idleIn();
      step();
      step();
      mAct = ~mAct;
   endtask

   task automatic test_reset();
      logic [30:0] obs;
      logic [30:0] exp;
      doReset();
      @(negedge clk);
      obs = {csnR, wrnR, addrR, wdtR, bankR, inReady,
             enDelay, clrAcc, enAcc, outValid, errAddr};
      exp = {1'b1, 1'b1, 6'd0, 16'd0, 1'b0, 1'b1, 5'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_outputs: got %b exp %b", obs, exp);
      end
      checks++;
      if ({inReady2, inReady64} !== 2'b11) begin
         errors++;
         $display("FAIL reset_ready_param: got %b exp 11",
                  {inReady2, inReady64});
      end
   endtask

   task automatic test_single_sample(input bit bnk);
      logic [AW+7:0] obs;
      logic [AW+7:0] exp;
      logic [AW-1:0] expA;
      bit            expRd;
      for (int i = 0; i <= N + 3; i++) begin
         step();
         inValid = (i == 0);
         sample = CW'($urandom);
         @(negedge clk);
         expRd = (i >= 1) && (i <= N);
         expA = expRd ? AW'(i - 1) : AW'(0);
         obs = {csnR, wrnR, bankR, addrR, enDelay, enAcc,
                clrAcc, outValid, inReady};
         exp = {~expRd, 1'b1, bnk, expA, (i == 0),
                (i >= 2 && i <= N + 1), (i == 2), (i == N + 2),
                (i == 0 || i >= N + 2)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single_sample c%0d: got %b exp %b",
                     i, obs, exp);
         end
      end
   endtask

   task automatic test_update_window();
      logic signed [CW-1:0] d;
      step();
      flag = 1'b1;
      @(negedge clk);
      checks++;
      if (inReady !== 1'b1) begin
         errors++;
         $display("FAIL upd_idle_ready: got %b exp 1", inReady);
      end
      for (int a = 0; a < N; a++) begin
         step();
         d = CW'($urandom);
         csn = 1'b0;
         wrn = 1'b0;
         addr = AW'(a);
         wdt = d;
         @(negedge clk);
         checks++;
         if ({csnR, wrnR, bankR, addrR, wdtR, inReady} !==
             {1'b0, 1'b0, ~mAct, AW'(a), d, 1'b0}) begin
            errors++;
            $display("FAIL upd_write a%0d: got %b/%b/%b/%0d/%h exp bank %b data %h",
                     a, csnR, wrnR, bankR, addrR, wdtR, ~mAct, d);
         end
         coefM[~mAct][a] = d;
      end
      step();
      idleIn();
      @(negedge clk);
      step();
      @(negedge clk);
      checks++;
      if ({inReady, csnR, bankR} !== {1'b0, 1'b1, mAct}) begin
         errors++;
         $display("FAIL upd_swap_cycle: got %b exp %b",
                  {inReady, csnR, bankR}, {1'b0, 1'b1, mAct});
      end
      mAct = ~mAct;
      step();
      @(negedge clk);
      checks++;
      if ({inReady, bankR} !== {1'b1, mAct}) begin
         errors++;
         $display("FAIL upd_after_swap: got %b exp %b",
                  {inReady, bankR}, {1'b1, mAct});
      end
   endtask

   task automatic test_err_addr();
      logic signed [CW-1:0] d;
      step();
      flag = 1'b1;
      step();
      csn = 1'b0;
      wrn = 1'b0;
      addr = AW'(12);
      wdt = CW'($urandom);
      @(negedge clk);
      checks++;
      if ({csnR, wrnR, addrR, wdtR, errAddr} !==
          {1'b1, 1'b1, 6'd0, 16'd0, 1'b0}) begin
         errors++;
         $display("FAIL err_suppress: got %b", {csnR, wrnR, addrR, wdtR, errAddr});
      end
      step();
      csn = 1'b1;
      wrn = 1'b1;
      @(negedge clk);
      checks++;
      if (errAddr !== 1'b1) begin
         errors++;
         $display("FAIL err_set: got %b exp 1", errAddr);
      end
      step();
      d = CW'($urandom);
      csn = 1'b0;
      wrn = 1'b0;
      addr = AW'(N - 1);
      wdt = d;
      @(negedge clk);
      checks++;
      if ({csnR, wrnR, addrR, wdtR} !== {1'b0, 1'b0, AW'(N - 1), d}) begin
         errors++;
         $display("FAIL err_edge_write: got %b/%b/%0d/%h exp 0/0/%0d/%h",
                  csnR, wrnR, addrR, wdtR, N - 1, d);
      end
      coefM[~mAct][N-1] = d;
      closeWindow();
      for (int i = 0; i < N + 4; i++) begin
         step();
         inValid = (i == 0);
         sample = CW'($urandom);
      end
      @(negedge clk);
      checks++;
      if (errAddr !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %b exp 1", errAddr);
      end
      doReset();
      @(negedge clk);
      checks++;
      if (errAddr !== 1'b0) begin
         errors++;
         $display("FAIL err_clear_reset: got %b exp 0", errAddr);
      end
   endtask

   task automatic test_simultaneous();
      logic signed [CW-1:0] d;
      step();
      inValid = 1'b1;
      flag = 1'b1;
      sample = CW'($urandom);
      @(negedge clk);
      checks++;
      if ({enDelay, inReady} !== 2'b11) begin
         errors++;
         $display("FAIL simul_accept: got %b exp 11", {enDelay, inReady});
      end
      for (int i = 1; i <= N + 1; i++) begin
         step();
         inValid = 1'b0;
         @(negedge clk);
         checks++;
         if (inReady !== 1'b0) begin
            errors++;
            $display("FAIL simul_ready c%0d: got %b exp 0", i, inReady);
         end
      end
      step();
      d = CW'($urandom);
      csn = 1'b0;
      wrn = 1'b0;
      addr = '0;
      wdt = d;
      @(negedge clk);
      checks++;
      if ({csnR, wrnR, bankR, addrR, wdtR, inReady, outValid} !==
          {1'b0, 1'b0, ~mAct, 6'd0, d, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL simul_write_after_drain: got %b/%b/%b/%0d/%h/%b/%b",
                  csnR, wrnR, bankR, addrR, wdtR, inReady, outValid);
      end
      coefM[~mAct][0] = d;
      for (int a = 1; a < N; a++) begin
         step();
         d = CW'($urandom);
         addr = AW'(a);
         wdt = d;
         coefM[~mAct][a] = d;
      end
      closeWindow();
   endtask

   task automatic test_reset_mid_write();
      logic signed [CW-1:0] d;
      int bad;
      step();
      flag = 1'b1;
      step();
      d = CW'($urandom);
      csn = 1'b0;
      wrn = 1'b0;
      addr = AW'(3);
      wdt = d;
      coefM[~mAct][3] = d;
      step();
      iRst = 1'b1;
      csn = 1'b1;
      wrn = 1'b1;
      step();
      iRst = 1'b0;
      idleIn();
      mAct = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if ({inReady, bankR} !== 2'b10) bad++;
         step();
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_mid_write: got %0d bad cycles exp 0", bad);
      end
   endtask

   task automatic test_reset_mid_mac();
      step();
      inValid = 1'b1;
      sample = CW'($urandom);
      for (int i = 1; i <= 4; i++) begin
         step();
         inValid = 1'b0;
      end
      step();
      iRst = 1'b1;
      @(negedge clk);
      checks++;
      if ({csnR, addrR} !== {1'b0, 6'd4}) begin
         errors++;
         $display("FAIL mac_tap4: got csn %b addr %0d exp 0/4", csnR, addrR);
      end
      step();
      iRst = 1'b0;
      mAct = 1'b0;
      @(negedge clk);
      checks++;
      if (inReady !== 1'b1) begin
         errors++;
         $display("FAIL mac_reset_ready: got %b exp 1", inReady);
      end
      for (int i = 0; i < N + 3; i++) begin
         checks++;
         if ({enAcc, outValid} !== 2'b00) begin
            errors++;
            $display("FAIL mac_reset_quiet c%0d: got %b exp 00",
                     i, {enAcc, outValid});
         end
         step();
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int h10 [$];
      int h2 [$];
      int h64 [$];
      int maxA;
      doReset();
      maxA = 0;
      for (int c = 0; c < 3 * 66 + 4; c++) begin
         step();
         inValid = 1'b1;
         sample = CW'($urandom);
         @(negedge clk);
         if (inReady) h10.push_back(cyc);
         if (inReady2) h2.push_back(cyc);
         if (inReady64) h64.push_back(cyc);
         if (!csn64 && wrn64 && int'(addr64) > maxA) maxA = int'(addr64);
      end
      step();
      inValid = 1'b0;
      checks++;
      if (h10.size() < 3 || h2.size() < 3 || h64.size() < 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d/%0d/%0d handshakes",
                  h10.size(), h2.size(), h64.size());
      end
      for (int k = 1; k < h10.size(); k++) begin
         checks++;
         if (h10[k] - h10[k-1] !== N + 2) begin
            errors++;
            $display("FAIL b2b_cadence10: got %0d exp %0d",
                     h10[k] - h10[k-1], N + 2);
         end
      end
      for (int k = 1; k < h2.size(); k++) begin
         checks++;
         if (h2[k] - h2[k-1] !== 4) begin
            errors++;
            $display("FAIL b2b_cadence2: got %0d exp 4", h2[k] - h2[k-1]);
         end
      end
      for (int k = 1; k < h64.size(); k++) begin
         checks++;
         if (h64[k] - h64[k-1] !== 66) begin
            errors++;
            $display("FAIL b2b_cadence64: got %0d exp 66", h64[k] - h64[k-1]);
         end
      end
      checks++;
      if (maxA !== 63) begin
         errors++;
         $display("FAIL b2b_addr64_top: got %0d exp 63", maxA);
      end
   endtask

   task automatic test_random_datapath();
      logic signed [CW-1:0] d;
      int gb;
      int eb;
      doReset();
      gb = gotQ.size();
      eb = expQ.size();
      step();
      flag = 1'b1;
      for (int a = 0; a < N; a++) begin
         if ($urandom_range(0, 2) == 0) begin
            step();
            csn = 1'b0;
            wrn = 1'b0;
            addr = AW'($urandom_range(N, 63));
            wdt = CW'($urandom);
         end
         step();
         d = CW'($urandom);
         csn = 1'b0;
         wrn = 1'b0;
         addr = AW'(a);
         wdt = d;
         coefM[~mAct][a] = d;
      end
      closeWindow();
      for (int c = 0; c < 20 * (N + 3); c++) begin
         step();
         inValid = ($urandom_range(0, 1) == 1);
         sample = CW'($urandom);
      end
      step();
      inValid = 1'b0;
      for (int c = 0; c < N + 4; c++) step();
      checks++;
      if (gotQ.size() - gb !== expQ.size() - eb || expQ.size() - eb < 5) begin
         errors++;
         $display("FAIL rand_count: got %0d outputs exp %0d",
                  gotQ.size() - gb, expQ.size() - eb);
      end
      for (int k = 0; k < expQ.size() - eb && k < gotQ.size() - gb; k++) begin
         checks++;
         if (gotQ[gb+k] !== expQ[eb+k]) begin
            errors++;
            $display("FAIL rand_output %0d: got %0d exp %0d",
                     k, gotQ[gb+k], expQ[eb+k]);
         end
      end
   endtask

   initial begin
      iRst = 1'b1;
      sample = '0;
      idleIn();
      mAct = 1'b0;
      foreach (coefM[b, k]) coefM[b][k] = '0;
      test_reset();
      test_single_sample(1'b0);
      test_update_window();
      test_single_sample(1'b1);
      test_err_addr();
      test_simultaneous();
      test_reset_mid_write();
      test_single_sample(1'b0);
      test_reset_mid_mac();
      test_back_to_back();
      test_random_datapath();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
